// File: rtl/ping_sequencer.sv
// ping_sequencer
//   Turns a one-cycle "ping" request into a timed transmit/receive cycle for
//   the transducer H-bridge: T/R switch settle, drive burst, ring-down
//   blanking, then the listen window. Every output is registered.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           ping request (level, sampled every edge)
//   abort           cancel a ping in progress
//   burst_len       drive duration in cycles      (latched at start)
//   blank_len       blanking duration in cycles   (latched at start)
//   listen_len      listen window in cycles       (latched at start)
//   clr_overrun     clears the sticky overrun flag
//   hstate          code to h_bridge (HS_IDLE / HS_DRIVE)
//   txrx            1 = transmit path, 0 = receive path
//   listen          high during the receive window
//   busy            high in any non-IDLE state
//   done            one-cycle pulse at the end of a completed ping
//   overrun         sticky: start seen while busy
//   ping_count      completed-ping counter, wraps 255 -> 0
//   state_dbg       current FSM state, for checkers
//
// Handshake: start is a plain level request. It is accepted only when the
// FSM is IDLE and abort is low; a start in any other state is dropped and
// flagged on overrun. There is no back-pressure.

`ifndef HB_OSCL
`define HB_OSCL 2'b01
`endif

module ping_sequencer #(
  parameter int          CNT_W      = 16,
  parameter int          SETTLE_CYC = 4,
  parameter logic [1:0]  HS_IDLE    = 2'b00,
  parameter logic [1:0]  HS_DRIVE   = `HB_OSCL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] blank_len,
  input  logic [CNT_W-1:0] listen_len,
  input  logic             clr_overrun,
  output logic [1:0]       hstate,
  output logic             txrx,
  output logic             listen,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [7:0]       ping_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    DRIVE  = 3'd2,
    BLANK  = 3'd3,
    LISTEN = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LEN = CNT_W'(SETTLE_CYC);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] burst_sh, blank_sh, listen_sh;

  // Phase that follows each timed phase, with zero-length phases skipped.
  state_t           after_blank_st, after_drive_st, after_settle_st;
  logic [CNT_W-1:0] after_blank_cnt, after_drive_cnt, after_settle_cnt;

  logic             accept;
  logic [1:0]       hstate_nxt;
  logic             txrx_nxt, listen_nxt, busy_nxt, done_nxt;

  assign accept    = (state == IDLE) && start && !abort;
  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // State register, counter and shadow lengths
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      burst_sh  <= '0;
      blank_sh  <= '0;
      listen_sh <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        burst_sh  <= burst_len;
        blank_sh  <= blank_len;
        listen_sh <= listen_len;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    if (listen_sh != '0) begin
      after_blank_st  = LISTEN;
      after_blank_cnt = listen_sh;
    end else begin
      after_blank_st  = DONE;
      after_blank_cnt = '0;
    end

    if (blank_sh != '0) begin
      after_drive_st  = BLANK;
      after_drive_cnt = blank_sh;
    end else begin
      after_drive_st  = after_blank_st;
      after_drive_cnt = after_blank_cnt;
    end

    if (burst_sh != '0) begin
      after_settle_st  = DRIVE;
      after_settle_cnt = burst_sh;
    end else begin
      after_settle_st  = after_drive_st;
      after_settle_cnt = after_drive_cnt;
    end
  end

  // Counters load N on phase entry and the phase exits on the cycle the
  // count reads 1, so every phase lasts exactly N cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LEN;
        end
      end
      SETTLE: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = after_settle_st;
          cnt_nxt   = after_settle_cnt;
        end
      end
      DRIVE: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = after_drive_st;
          cnt_nxt   = after_drive_cnt;
        end
      end
      BLANK: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = after_blank_st;
          cnt_nxt   = after_blank_cnt;
        end
      end
      LISTEN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Output logic: decoded from the next state and registered, so hstate and
  // txrx always change on the same edge and HS_DRIVE never meets txrx=0.
  // ---------------------------------------------------------------------
  always_comb begin
    hstate_nxt = HS_IDLE;
    txrx_nxt   = 1'b0;
    listen_nxt = 1'b0;
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = 1'b0;
    case (state_nxt)
      SETTLE: txrx_nxt = 1'b1;
      DRIVE: begin
        txrx_nxt   = 1'b1;
        hstate_nxt = HS_DRIVE;
      end
      BLANK:  txrx_nxt   = 1'b1;
      LISTEN: listen_nxt = 1'b1;
      DONE:   done_nxt   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hstate     <= HS_IDLE;
      txrx       <= 1'b0;
      listen     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      ping_count <= '0;
    end else begin
      hstate <= hstate_nxt;
      txrx   <= txrx_nxt;
      listen <= listen_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      if (done_nxt) begin
        ping_count <= ping_count + 8'd1;
      end
      // Abort outranks start, so a start alongside abort is dropped silently.
      if (start && !abort && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ping_sequencer.sv
// Directed bench for ping_sequencer. Cycle 0 is the cycle in which start is
// held high; cycle c is observed on the falling edge c cycles later.
module tb_ping_sequencer;

  localparam logic [1:0] HS_IDLE  = 2'b00;
  localparam logic [1:0] HS_DRIVE = 2'b01;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] burst_len;
  logic [15:0] blank_len;
  logic [15:0] listen_len;
  logic        clr_overrun;
  logic [1:0]  hstate;
  logic        txrx;
  logic        listen;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [7:0]  ping_count;
  logic [2:0]  state_dbg;

  int          n_compared;
  int          n_mismatched;
  logic [7:0]  exp_count;

  ping_sequencer #(
    .CNT_W      (16),
    .SETTLE_CYC (4),
    .HS_IDLE    (HS_IDLE),
    .HS_DRIVE   (HS_DRIVE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .burst_len   (burst_len),
    .blank_len   (blank_len),
    .listen_len  (listen_len),
    .clr_overrun (clr_overrun),
    .hstate      (hstate),
    .txrx        (txrx),
    .listen      (listen),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .ping_count  (ping_count),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {hstate, txrx, listen, busy, done} in cycle c of an undisturbed
  // ping: settle 1..4, drive, blank, listen, then one done cycle.
  function automatic logic [5:0] exp_vec(int c, int b, int bl, int l);
    int d_end;
    int k_end;
    int l_end;
    d_end = 4 + b;
    k_end = d_end + bl;
    l_end = k_end + l;
    if (c < 1)          return 6'b0;
    if (c <= 4)         return {HS_IDLE,  1'b1, 1'b0, 1'b1, 1'b0};
    if (c <= d_end)     return {HS_DRIVE, 1'b1, 1'b0, 1'b1, 1'b0};
    if (c <= k_end)     return {HS_IDLE,  1'b1, 1'b0, 1'b1, 1'b0};
    if (c <= l_end)     return {HS_IDLE,  1'b0, 1'b1, 1'b1, 1'b0};
    if (c == l_end + 1) return {HS_IDLE,  1'b0, 1'b0, 1'b1, 1'b1};
    return 6'b0;
  endfunction

  // ---------------------------------------------------------------------
  // Driver: one ping of n cycles after the start cycle. Event cycles of -1
  // mean "not used": ovr_c re-asserts start (with clr_overrun) while busy,
  // abort_c pulses abort, cfg_c changes burst_len to 3, rst_c pulses rst.
  // ---------------------------------------------------------------------
  task automatic run_ping(input int b, input int bl, input int l, input int n,
                          input int ovr_c, input int abort_c, input int cfg_c,
                          input int rst_c);
    int          done_c;
    logic        killed;
    logic [5:0]  obs;
    done_c = 4 + b + bl + l + 1;
    @(negedge clk);
    burst_len  = 16'(b);
    blank_len  = 16'(bl);
    listen_len = 16'(l);
    start      = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      killed = ((abort_c >= 0) && (c > abort_c)) || ((rst_c >= 0) && (c > rst_c));
      if ((rst_c >= 0) && (c == rst_c + 1)) begin
        exp_count = 8'd0;
      end else if (!killed && (c == done_c)) begin
        exp_count = exp_count + 8'd1;
      end
      obs = {hstate, txrx, listen, busy, done};
      check($sformatf("outputs b%0d/%0d/%0d c%0d", b, bl, l, c), 32'(obs),
            32'(killed ? 6'b0 : exp_vec(c, b, bl, l)));
      check($sformatf("ping_count c%0d", c), 32'(ping_count), 32'(exp_count));
      if (ovr_c >= 0) begin
        check($sformatf("overrun c%0d", c), 32'(overrun), 32'(c > ovr_c));
      end
      start       = (c == ovr_c);
      clr_overrun = (c == ovr_c);
      abort       = (c == abort_c);
      rst         = (c == rst_c);
      if (c == cfg_c) burst_len = 16'd3;
    end
    start       = 1'b0;
    clr_overrun = 1'b0;
    abort       = 1'b0;
    rst         = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    exp_count    = 8'd0;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    clr_overrun  = 1'b0;
    burst_len    = 16'd0;
    blank_len    = 16'd0;
    listen_len   = 16'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'({hstate, txrx, listen, busy, done, overrun}), 32'd0);
    check("reset ping_count", 32'(ping_count), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // Nominal ping
    run_ping(10, 5, 20, 42, -1, -1, -1, -1);
    check("nominal overrun", 32'(overrun), 32'd0);
    check("nominal idle state", 32'(state_dbg), 32'd0);

    // Zero-length drive and blank
    run_ping(0, 0, 3, 10, -1, -1, -1, -1);

    // Start while busy at cycle 12, with clr_overrun in the same cycle
    run_ping(10, 5, 20, 42, 12, -1, -1, -1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun cleared", 32'(overrun), 32'd0);

    // Abort at cycle 8, then a fresh ping starting at cycle 10
    run_ping(10, 5, 20, 9, -1, 8, -1, -1);
    run_ping(10, 5, 20, 42, -1, -1, -1, -1);

    // burst_len change during DRIVE has no effect
    run_ping(10, 5, 20, 42, -1, -1, 7, -1);

    // Reset mid-ping at cycle 6
    run_ping(10, 5, 20, 8, -1, -1, -1, 6);
    check("post-reset state", 32'(state_dbg), 32'd0);

    // 256 back-to-back minimum pings: counter wraps back to zero
    for (int i = 0; i < 256; i++) begin
      run_ping(0, 0, 0, 5, -1, -1, -1, -1);
    end
    check("ping_count wrap", 32'(ping_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
